// File: rtl/pc_fetch_sequencer.sv
// Fetch/issue sequencer downstream of the 8-bit program counter: fetches each
// instruction byte over req/ack, issues it over valid/ready, and steers the counter.
module pc_fetch_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 15,
    parameter int unsigned SKIP_DIST   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [7:0] pc,
    input  logic       cond_in,
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [7:0] instr,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic       pc_en,
    output logic       pc_load,
    output logic [7:0] pc_load_val,
    output logic       halted,
    output logic       err
);

    localparam int unsigned W  = 8;
    localparam int unsigned TW = 8;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] OPC_OP   = 2'b00;
    localparam logic [1:0] OPC_JMP  = 2'b01;
    localparam logic [1:0] OPC_SKIP = 2'b10;
    localparam logic [1:0] OPC_HALT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_OPND, S_SETTLE, S_HALT, S_ERR
    } state_t;

    state_t        state, state_nx;
    logic [W-1:0]  ir, ir_nx;
    logic [TW-1:0] tmo, tmo_nx;
    logic [W-1:0]  mem_addr_nx, instr_nx, pc_load_val_nx;
    logic          mem_req_nx, instr_valid_nx, pc_en_nx, pc_load_nx, halted_nx, err_nx;
    logic [W-1:0]  settle_pc;

    // Value the counter will hold after the pulse currently on pc_en/pc_load lands.
    assign settle_pc = pc_load ? pc_load_val : (pc_en ? W'(pc + W'(1)) : pc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ir          <= '0;
            tmo         <= '0;
            mem_addr    <= '0;
            mem_req     <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            pc_en       <= 1'b0;
            pc_load     <= 1'b0;
            pc_load_val <= '0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_nx;
            ir          <= ir_nx;
            tmo         <= tmo_nx;
            mem_addr    <= mem_addr_nx;
            mem_req     <= mem_req_nx;
            instr       <= instr_nx;
            instr_valid <= instr_valid_nx;
            pc_en       <= pc_en_nx;
            pc_load     <= pc_load_nx;
            pc_load_val <= pc_load_val_nx;
            halted      <= halted_nx;
            err         <= err_nx;
        end
    end

    // Next state plus next value of every registered output.
    always_comb begin
        state_nx       = state;
        ir_nx          = ir;
        tmo_nx         = tmo;
        mem_addr_nx    = mem_addr;
        mem_req_nx     = 1'b0;
        instr_nx       = instr;
        instr_valid_nx = 1'b0;
        pc_en_nx       = 1'b0;
        pc_load_nx     = 1'b0;
        pc_load_val_nx = pc_load_val;
        halted_nx      = halted;
        err_nx         = err;

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_nx    = S_FETCH;
                    mem_req_nx  = 1'b1;
                    mem_addr_nx = pc;
                    tmo_nx      = '0;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    ir_nx    = mem_rdata;
                    state_nx = S_DECODE;
                end else if (tmo == TMO_LAST) begin
                    state_nx = S_ERR;
                    err_nx   = 1'b1;
                end else begin
                    mem_req_nx = 1'b1;
                    tmo_nx     = TW'(tmo + TW'(1));
                end
            end
            S_DECODE: begin
                case (ir[7:6])
                    OPC_OP: begin
                        state_nx       = S_ISSUE;
                        instr_valid_nx = 1'b1;
                        instr_nx       = ir;
                    end
                    OPC_JMP: begin
                        state_nx    = S_OPND;
                        mem_req_nx  = 1'b1;
                        mem_addr_nx = W'(pc + W'(1));
                        tmo_nx      = '0;
                    end
                    OPC_SKIP: begin
                        state_nx = S_SETTLE;
                        if (cond_in) begin
                            pc_load_nx     = 1'b1;
                            pc_load_val_nx = W'(pc + W'(SKIP_DIST));
                        end else begin
                            pc_en_nx = 1'b1;
                        end
                    end
                    OPC_HALT: begin
                        state_nx  = S_HALT;
                        halted_nx = 1'b1;
                    end
                endcase
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    state_nx = S_SETTLE;
                    pc_en_nx = 1'b1;
                end else begin
                    instr_valid_nx = 1'b1;
                end
            end
            S_OPND: begin
                if (mem_ack) begin
                    state_nx       = S_SETTLE;
                    pc_load_nx     = 1'b1;
                    pc_load_val_nx = mem_rdata;
                end else if (tmo == TMO_LAST) begin
                    state_nx = S_ERR;
                    err_nx   = 1'b1;
                end else begin
                    mem_req_nx = 1'b1;
                    tmo_nx     = TW'(tmo + TW'(1));
                end
            end
            S_SETTLE: begin
                if (run) begin
                    state_nx    = S_FETCH;
                    mem_req_nx  = 1'b1;
                    mem_addr_nx = settle_pc;
                    tmo_nx      = '0;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_HALT: ;
            S_ERR: ;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
